instr_fetch_ctrl: RTL and testbench

Fetch controller that sequences Instr_Memory for the RISC-V core.
- Owns the fetch PC and drives Instr_Memory's 8-bit address.
- Captures the returned 32-bit word into a 2-entry prefetch buffer.
- Hands instructions to decode over a valid/ready handshake.
- Accepts redirects (branch/jump targets) that flush the buffer and restart fetch.

---
 rtl/instr_fetch_ctrl.sv | 159 +++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Purpose: fetch controller; owns the fetch PC, reads Instr_Memory, queues words in a 2-entry prefetch buffer.
// Latency: instruction visible one edge after it is fetched; redirect target fetched on the edge after the redirect.
// Backpressure: instr_ready=0 with a full buffer freezes fetch PC and imem_addr; nothing is dropped or duplicated.
//
// Ports:
//   clk, reset                     system clock, asynchronous active-high reset
//   fetch_en                       0 freezes the fetch PC and buffer pushes (buffer still drains)
//   imem_addr / imem_rd            address to Instr_Memory (= fetch PC) and its combinational read data
//   redirect_valid / redirect_pc   one-cycle redirect; flushes the buffer and restarts fetch at the target
//   instr_valid/instr_ready        handshake with decode; instr / instr_pc are the buffer head
//   halted                         fetch stopped on a self-loop jal (only with FETCH_SELF_LOOP_HALT_EN)
//
// Build option: define FETCH_SELF_LOOP_HALT_EN to stop fetching after a pushed "jal x0,0".
module instr_fetch_ctrl #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rd,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

`ifdef FETCH_SELF_LOOP_HALT_EN
  localparam logic [31:0] SELF_LOOP = 32'h0000_006F;  // jal x0,0
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1} state_t;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fpc;
  logic [CNT_W-1:0]  count;
  logic [31:0]       e0_dat, e1_dat;   // e0 is always the head
  logic [ADDR_W-1:0] e0_pc, e1_pc;
  logic              fetch_ok;
  logic              full, pop, push;

  assign imem_addr   = fpc;
  assign instr_valid = (count != '0);
  assign instr       = e0_dat;
  assign instr_pc    = e0_pc;

  assign full = (count == CNT_W'(BUF_DEPTH));
  assign pop  = instr_valid & instr_ready;
  // A full buffer can still accept a word when the head leaves on the same edge.
  assign push = fetch_ok & fetch_en & ~redirect_valid & (~full | pop);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = fetch_en ? S_RUN : S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (fetch_en)  state_nxt = S_RUN;
        S_RUN:   if (!fetch_en) state_nxt = S_IDLE;
`ifdef FETCH_SELF_LOOP_HALT_EN
        S_HALT:  state_nxt = S_HALT;
`endif
        default: state_nxt = S_IDLE;
      endcase
`ifdef FETCH_SELF_LOOP_HALT_EN
      // push already excludes redirect, so this only fires on a real fetch
      if (push && (imem_rd == SELF_LOOP)) state_nxt = S_HALT;
`endif
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    fetch_ok = 1'b0;
    halted   = 1'b0;
    case (state)
      S_RUN:   fetch_ok = 1'b1;
      S_IDLE:  fetch_ok = fetch_en;   // first push happens on the IDLE->RUN edge
`ifdef FETCH_SELF_LOOP_HALT_EN
      S_HALT:  halted   = 1'b1;
`endif
      default: fetch_ok = 1'b0;
    endcase
  end

  // ---------------- fetch PC ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc <= RESET_PC;
    end else if (redirect_valid) begin
      fpc <= redirect_pc & ~ADDR_W'(3);   // targets are word aligned
    end else if (push) begin
      fpc <= fpc + ADDR_W'(4);            // wraps naturally at 2^ADDR_W
    end
  end

  // ---------------- prefetch buffer ----------------
  // Shift organisation: the head always lives in e0, so when the buffer empties
  // e0 simply keeps the last instruction and the outputs hold their value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      e0_dat <= '0;
      e0_pc  <= '0;
      e1_dat <= '0;
      e1_pc  <= '0;
    end else if (redirect_valid) begin
      count <= '0;   // flush; a same-cycle pop is implicitly honoured
    end else begin
      case ({push, pop})
        2'b11: begin
          if (full) begin
            e0_dat <= e1_dat;
            e0_pc  <= e1_pc;
            e1_dat <= imem_rd;
            e1_pc  <= fpc;
          end else begin
            e0_dat <= imem_rd;
            e0_pc  <= fpc;
          end
        end
        2'b10: begin
          if (count == '0) begin
            e0_dat <= imem_rd;
            e0_pc  <= fpc;
          end else begin
            e1_dat <= imem_rd;
            e1_pc  <= fpc;
          end
          count <= count + CNT_W'(1);
        end
        2'b01: begin
          if (full) begin
            e0_dat <= e1_dat;
            e0_pc  <= e1_pc;
          end
          count <= count - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

`ifdef FETCH_SELF_LOOP_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        halted;

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  assign imem_rd = mem[imem_addr[7:2]];

  instr_fetch_ctrl dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_rd(imem_rd), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .halted(halted)
  );

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] w; logic [7:0] pc; } ent_t;
  ent_t       q[$];
  ent_t       last;       // what decode sees at the head (held when empty)
  logic [7:0] m_fpc;
  bit         m_halt;
  int         loop_deliv;
  int         checks = 0;
  int         errors = 0;

  logic [49:0] dut_vec;
  assign dut_vec = {instr_valid, instr, instr_pc, imem_addr, halted};

  function automatic logic [49:0] exp_vec();
    return {q.size() != 0, last.w, last.pc, m_fpc, m_halt};
  endfunction

  task automatic model_reset();
    q.delete();
    last   = '0;
    m_fpc  = 8'h00;
    m_halt = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit   pop;
    int   sz;
    ent_t e;
    sz  = q.size();
    pop = (sz > 0) && instr_ready;
    if (pop && q[0].pc == 8'h30) loop_deliv++;
    if (redirect_valid) begin
      q.delete();
      m_fpc  = redirect_pc & 8'hFC;
      m_halt = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (fetch_en && !m_halt && (sz < 2 || pop)) begin
        e.w  = mem[m_fpc[7:2]];
        e.pc = m_fpc;
        q.push_back(e);
        if (HALT_EN && e.w == 32'h0000006F) m_halt = 1'b1;
        m_fpc = m_fpc + 8'd4;
      end
    end
    if (q.size() > 0) last = q[0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    fetch_en       = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    reset          = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    fetch_en = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00;
    reset = 1'b1;
    #3;
    checks++;
    if (dut_vec !== {1'b0, 32'h0, 8'h00, 8'h00, 1'b0}) begin
      errors++; $display("FAIL reset_state: got %h want %h", dut_vec, {1'b0, 32'h0, 8'h00, 8'h00, 1'b0});
    end
    fetch_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    logic [31:0] prog [4];
    prog[0] = 32'h00000013; prog[1] = 32'h00006093; prog[2] = 32'h00106113; prog[3] = 32'h00006313;
    fetch_en = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL seq_model cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, prog[i-1], 8'((i-1)*4)}) begin
          errors++; $display("FAIL seq_prog cyc%0d: got %h@%h v=%b want %h@%h", i, instr, instr_pc, instr_valid, prog[i-1], 8'((i-1)*4));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL stall_model cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      tick();
    end
    checks++;
    if ({instr_valid, instr, imem_addr} !== {1'b1, 32'h00000013, 8'h08}) begin
      errors++; $display("FAIL stall_frozen: got v=%b %h addr=%h want 1 00000013 addr=08", instr_valid, instr, imem_addr);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL stall_release cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      if (i == 1) begin
        checks++;
        if ({instr, instr_pc} !== {32'h00006093, 8'h04}) begin
          errors++; $display("FAIL stall_next: got %h@%h want 00006093@04", instr, instr_pc);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 8'h46; instr_ready = 1'($urandom_range(0, 1));
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b1;
    checks++;
    if ({instr_valid, imem_addr} !== {1'b0, 8'h44}) begin
      errors++; $display("FAIL redir_flush: got v=%b addr=%h want v=0 addr=44", instr_valid, imem_addr);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL redir_model cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      if (instr_valid && instr_pc < 8'h44) begin
        errors++; $display("FAIL redir_stale: got pc %h want >=44", instr_pc);
      end
      tick();
      if (i == 0) begin
        checks++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hfd5ff06f, 8'h44}) begin
          errors++; $display("FAIL redir_target: got v=%b %h@%h want fd5ff06f@44", instr_valid, instr, instr_pc);
        end
      end
    end
  endtask

  task automatic test_wrap();
    fetch_en = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'hFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if ({instr_valid, instr, instr_pc, imem_addr} !== {1'b1, 32'h0, 8'hFC, 8'h00}) begin
      errors++; $display("FAIL wrap_fc: got v=%b %h@%h addr=%h want 00000000@fc addr=00", instr_valid, instr, instr_pc, imem_addr);
    end
    tick();
    checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h00000013, 8'h00}) begin
      errors++; $display("FAIL wrap_00: got v=%b %h@%h want 00000013@00", instr_valid, instr, instr_pc);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL wrap_model: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    fetch_en = 1'b1; instr_ready = 1'b1;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({instr_valid, instr, instr_pc, imem_addr, halted} !== {1'b0, 32'h0, 8'h00, 8'h00, 1'b0}) begin
      errors++; $display("FAIL async_reset: got %h want all zero", dut_vec);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL async_resume cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_self_loop();
    logic [31:0] saved;
    saved   = mem[12];
    mem[12] = 32'h0000006F;
    loop_deliv = 0;
    fetch_en = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'h28;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL loop_model cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      tick();
    end
    checks++;
    if (HALT_EN) begin
      if ({halted, imem_addr} !== {1'b1, 8'h34} || loop_deliv != 1) begin
        errors++; $display("FAIL loop_halt: got halted=%b addr=%h deliv=%0d want 1 34 1", halted, imem_addr, loop_deliv);
      end
    end else begin
      if (halted !== 1'b0) begin
        errors++; $display("FAIL loop_nohalt: got halted=%b want 0", halted);
      end
    end
    redirect_valid = 1'b1; redirect_pc = 8'h00;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({halted, imem_addr} !== {1'b0, 8'h00}) begin
      errors++; $display("FAIL loop_clear: got halted=%b addr=%h want 0 00", halted, imem_addr);
    end
    mem[12] = saved;
    repeat (2) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      fetch_en       = ($urandom_range(0, 7) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 8'($urandom);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if (mem[i] == 32'h0000006F) mem[i] = 32'h00000013;
    end
    mem[0]  = 32'h00000013;
    mem[1]  = 32'h00006093;
    mem[2]  = 32'h00106113;
    mem[3]  = 32'h00006313;
    mem[17] = 32'hfd5ff06f;
    mem[63] = 32'h00000000;
    reset = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    model_reset();
    @(posedge clk);
    #1;

    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_self_loop();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
